// File: rtl/code_loader_pkg.sv
// Shared constants and state encoding for the boot-time code loader.
package code_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_LEN  = 3'd0;
  localparam state_t S_DATA = 3'd1;
  localparam state_t S_CHK  = 3'd2;
  localparam state_t S_ACK  = 3'd3;
  localparam state_t S_NAK  = 3'd4;
  localparam state_t S_DONE = 3'd5;
  localparam state_t S_ERR  = 3'd6;

  localparam logic [7:0] ACK_DEFAULT = 8'hAA;
  localparam logic [7:0] NAK_DEFAULT = 8'h55;

  localparam int BIDX_W = 2;

endpackage

// File: rtl/code_loader_byte_to_word_packer.sv
// Big-endian byte-to-word packer: word_valid pulses combinationally with the
// 4th byte, and word presents the fully assembled value in that same cycle.
module byte_to_word_packer
  import code_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [BIDX_W-1:0] idx;
  logic [23:0]       sh;

  assign word       = {sh, in_data};
  assign word_valid = in_valid && (idx == {BIDX_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      sh  <= '0;
    end else if (in_valid) begin
      idx <= idx + 1'b1;
      sh  <= {sh[15:0], in_data};
    end
  end

endmodule

// File: rtl/code_loader.sv
// Boot loader: length header, data words into code memory, then ACK/NAK to host.
// Optional trailing XOR checksum byte enabled by CODE_LOADER_CHECKSUM_EN.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int unsigned CODE_SIZE = 32767,
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [7:0]  ACK_BYTE  = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE  = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_we,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [31:0] MAX_WORDS = 32'(CODE_SIZE) + 32'd1 - BASE_ADDR;

`ifdef CODE_LOADER_CHECKSUM_EN
  localparam state_t S_POST_DATA = S_CHK;
  logic [7:0] chk;
`else
  localparam state_t S_POST_DATA = S_ACK;
`endif

  state_t      state;
  logic [31:0] len;
  logic [31:0] word_cnt;
  logic        pk_in_valid;
  logic        pk_valid;
  logic [31:0] pk_word;

  // One packer serves header and data: its index is back at 0 after the header.
  assign pk_in_valid = rx_valid && (state == S_LEN || state == S_DATA);

  byte_to_word_packer u_pack (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (pk_in_valid),
    .in_data    (rx_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN;
      len        <= '0;
      word_cnt   <= '0;
      mem_we     <= 1'b0;
      mem_w_addr <= BASE_ADDR;
      mem_w_data <= '0;
      load_err   <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
      chk        <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_LEN: if (pk_valid) begin
          len      <= pk_word;
          word_cnt <= '0;
          if (pk_word == 32'd0) state <= S_POST_DATA;
          else if (pk_word > MAX_WORDS) begin
            load_err <= 1'b1;
            state    <= S_NAK;
          end else state <= S_DATA;
        end
        S_DATA: begin
`ifdef CODE_LOADER_CHECKSUM_EN
          if (rx_valid) chk <= chk ^ rx_data;
`endif
          if (pk_valid) begin
            mem_we     <= 1'b1;
            mem_w_addr <= BASE_ADDR + word_cnt;
            mem_w_data <= pk_word;
            word_cnt   <= word_cnt + 32'd1;
            if (word_cnt == len - 32'd1) state <= S_POST_DATA;
          end
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        S_CHK: if (rx_valid) begin
          if (rx_data == chk) state <= S_ACK;
          else begin
            load_err <= 1'b1;
            state    <= S_NAK;
          end
        end
`endif
        S_ACK: if (tx_ready) state <= S_DONE;
        S_NAK: if (tx_ready) state <= S_ERR;
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (state == S_ACK) tx_data = ACK_BYTE;
    else if (state == S_NAK) tx_data = NAK_BYTE;
  end

  assign tx_valid  = (state == S_ACK) || (state == S_NAK);
  assign cpu_hold  = (state != S_DONE);
  assign load_done = (state == S_DONE);

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: vector table, hand sequences, random loads.
module tb_code_loader;

  localparam int MAXW = 32768;
  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [7:0] NAK = 8'h55;

  logic        clk = 1'b0;
  logic        rst, rx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        mem_we, tx_valid, cpu_hold, load_done, load_err;
  logic [31:0] mem_w_addr, mem_w_data;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  code_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_we     (mem_we),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t wq[$];
  always @(negedge clk) if (mem_we) wq.push_back('{mem_w_addr, mem_w_data});

  typedef struct {
    int n; logic [31:0] w0; logic [31:0] w1; bit bad; int gap; int rdy;
    logic [7:0] etx; bit edone; bit eerr; int enwr;
  } vec_t;

  int          nchk = 0, nerr = 0;
  logic [31:0] wdata [0:63];
  logic [7:0]  bq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) bq.push_back(w[i*8 +: 8]);
  endtask

  task automatic send_q(input int gapmax);
    while (bq.size() > 0) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = bq.pop_front();
      repeat ($urandom_range(gapmax, 0)) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] xsum(input int n);
    logic [7:0] x = 8'h00;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 4; b++) x = x ^ wdata[k][b*8 +: 8];
    return x;
  endfunction

  // Reference outcome of a load, from the length limit and checksum rule only.
  function automatic bit model_ack(input int n, input bit bad);
`ifdef CODE_LOADER_CHECKSUM_EN
    return (n <= MAXW) && !bad;
`else
    return (n <= MAXW);
`endif
  endfunction

  task automatic run_load(input string tag, input int n, input bit bad, input int gapmax,
                          input int rdy, input logic [7:0] etx, input bit edone,
                          input bit eerr, input int enwr);
    int cyc;
    do_reset();
    push_word(32'(n));
    if (n <= MAXW) begin
      for (int k = 0; k < n; k++) push_word(wdata[k]);
`ifdef CODE_LOADER_CHECKSUM_EN
      bq.push_back(xsum(n) ^ (bad ? 8'h01 : 8'h00));
`endif
    end else begin
      bq.push_back(8'h12);
      bq.push_back(8'h34);
    end
    send_q(gapmax);
    cyc = 0;
    while (!tx_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " tx_valid"}, 32'(tx_valid), 32'd1);
    check({tag, " tx_data"}, 32'(tx_data), 32'(etx));
    check({tag, " hold_pre"}, 32'(cpu_hold), 32'd1);
    for (int i = 0; i < rdy; i++) begin
      @(negedge clk);
      check({tag, " stall"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, etx});
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check({tag, " status"}, {28'd0, load_done, load_err, cpu_hold, tx_valid},
          {28'd0, edone, eerr, ~edone, 1'b0});
    bq.push_back(8'hA5);
    send_q(0);
    repeat (2) @(negedge clk);
    check({tag, " status_post"}, {28'd0, load_done, load_err, cpu_hold, tx_valid},
          {28'd0, edone, eerr, ~edone, 1'b0});
    check({tag, " nwr"}, 32'(wq.size()), 32'(enwr));
    for (int k = 0; k < wq.size() && k < enwr; k++) begin
      check({tag, " addr"}, wq[k].a, 32'(k));
      check({tag, " data"}, wq[k].d, wdata[k]);
    end
  endtask

  vec_t tv[6];

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;

    tv[0] = '{2, 32'hDEADBEEF, 32'h00000013, 1'b0, 0, 0, ACK, 1'b1, 1'b0, 2};
    tv[1] = '{0, 32'h0, 32'h0, 1'b0, 1, 0, ACK, 1'b1, 1'b0, 0};
    tv[2] = '{32769, 32'h0, 32'h0, 1'b0, 0, 0, NAK, 1'b0, 1'b1, 0};
    tv[3] = '{2, 32'h12345678, 32'h9ABCDEF0, 1'b0, 2, 10, ACK, 1'b1, 1'b0, 2};
    tv[4] = '{1, 32'h01020304, 32'h0, 1'b0, 0, 3, ACK, 1'b1, 1'b0, 1};
`ifdef CODE_LOADER_CHECKSUM_EN
    tv[5] = '{1, 32'h01020304, 32'h0, 1'b1, 0, 0, NAK, 1'b0, 1'b1, 1};
`else
    tv[5] = '{1, 32'h01020304, 32'h0, 1'b1, 0, 0, ACK, 1'b1, 1'b0, 1};
`endif

    // Reset values
    do_reset();
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst addr", mem_w_addr, 32'd0);
    check("rst data", mem_w_data, 32'd0);
    check("rst tx", {23'd0, tx_valid, tx_data}, 32'd0);
    check("rst flags", {29'd0, cpu_hold, load_done, load_err}, 32'b100);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 64; k++) wdata[k] = $urandom;
      wdata[0] = tv[i].w0;
      wdata[1] = tv[i].w1;
      run_load($sformatf("vec%0d", i), tv[i].n, tv[i].bad, tv[i].gap, tv[i].rdy,
               tv[i].etx, tv[i].edone, tv[i].eerr, tv[i].enwr);
    end

    // Reset after half of word 1: only word 0 written, then a clean reload.
    do_reset();
    push_word(32'd2);
    push_word(32'hDEADBEEF);
    bq.push_back(8'hDE);
    bq.push_back(8'hAD);
    send_q(0);
    repeat (3) @(negedge clk);
    check("midrst nwr", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) check("midrst d0", wq[0].d, 32'hDEADBEEF);
    do_reset();
    repeat (3) @(negedge clk);
    check("midrst nwr_after", 32'(wq.size()), 32'd0);
    check("midrst flags", {29'd0, cpu_hold, load_done, load_err}, 32'b100);
    wdata[0] = 32'hCAFEF00D;
    run_load("reload", 1, 1'b0, 0, 0, ACK, 1'b1, 1'b0, 1);

    // Largest legal length is accepted and starts writing at address 0.
    do_reset();
    push_word(32'd32768);
    push_word(32'h11223344);
    send_q(1);
    repeat (3) @(negedge clk);
    check("max_len tx/err", {30'd0, tx_valid, load_err}, 32'd0);
    check("max_len nwr", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      check("max_len addr", wq[0].a, 32'd0);
      check("max_len data", wq[0].d, 32'h11223344);
    end

    for (int r = 0; r < 8; r++) begin
      int  n;
      bit  bad, ack;
      n   = (r == 7) ? MAXW + int'($urandom_range(500, 1)) : int'($urandom_range(8, 1));
      bad = 1'($urandom_range(1, 0));
      for (int k = 0; k < 64; k++) wdata[k] = $urandom;
      ack = model_ack(n, bad);
      run_load($sformatf("rnd%0d", r), n, bad, 2, int'($urandom_range(4, 0)),
               ack ? ACK : NAK, ack, !ack, (n <= MAXW) ? n : 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
